// File: rtl/lut_ram_bist.sv
`timescale 1ns/1ps
// March C- style self-test engine for a lut_ram instance.
// Sequence: write P up, (read P / write ~P) up, (read ~P / write P) down, read P up.
// The first mismatch aborts the run and latches its address, read data and expected data.
module lut_ram_bist #(
    parameter int          LUT_WIDTH = 32,
    parameter int          LUT_DEPTH = 1000,
    parameter logic [31:0] DATA_BG   = 32'h5555_5555,
    parameter int          ADDR_W    = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [LUT_WIDTH-1:0] fail_data,
    output logic [LUT_WIDTH-1:0] fail_exp,
    output logic                 mem_wr_en,
    output logic [ADDR_W-1:0]    mem_wr_addr,
    output logic [LUT_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [LUT_WIDTH-1:0] mem_rd_data
);

    localparam logic [LUT_WIDTH-1:0] PAT  = LUT_WIDTH'(DATA_BG);
    localparam logic [ADDR_W-1:0]    LAST = ADDR_W'(LUT_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, M0_WR, M1_RW, M2_RW, M3_RD, DONE} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    addr;
    logic [LUT_WIDTH-1:0] exp_data;
    logic                 cmp_en;
    logic                 mismatch;
    logic                 at_last;

    // Read and write share one address; the RAM read is combinational.
    assign mem_wr_addr = addr;
    assign mem_rd_addr = addr;

    // Expected read value per element, and end-of-element detection by compare (never wrap).
    always_comb begin
        exp_data = PAT;
        cmp_en   = 1'b0;
        case (state)
            M1_RW:   cmp_en = 1'b1;
            M2_RW:   begin cmp_en = 1'b1; exp_data = ~PAT; end
            M3_RD:   cmp_en = 1'b1;
            default: ;
        endcase
        mismatch = cmp_en && (mem_rd_data != exp_data);
        at_last  = (state == M2_RW) ? (addr == '0) : (addr == LAST);
    end

    // Sequencer: state, address counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            fail_exp    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= M0_WR;
                        addr        <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail_addr   <= '0;
                        fail_data   <= '0;
                        fail_exp    <= '0;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= PAT;
                    end
                end
                default: begin
                    if (mismatch) begin
                        // This cycle's write still lands at this edge; the run is aborted.
                        state       <= DONE;
                        addr        <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        fail_addr   <= addr;
                        fail_data   <= mem_rd_data;
                        fail_exp    <= exp_data;
                        mem_wr_en   <= 1'b0;
                        mem_wr_data <= '0;
                    end else if (at_last) begin
                        case (state)
                            M0_WR: begin
                                state       <= M1_RW;
                                addr        <= '0;
                                mem_wr_data <= ~PAT;
                            end
                            M1_RW: begin
                                state       <= M2_RW;
                                addr        <= LAST;
                                mem_wr_data <= PAT;
                            end
                            M2_RW: begin
                                state     <= M3_RD;
                                addr      <= '0;
                                mem_wr_en <= 1'b0;
                            end
                            default: begin
                                state       <= DONE;
                                addr        <= '0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                pass        <= 1'b1;
                                mem_wr_en   <= 1'b0;
                                mem_wr_data <= '0;
                            end
                        endcase
                    end else if (state == M2_RW) begin
                        addr <= addr - ADDR_W'(1);
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
